// File: rtl/mod_counter_pkg.sv
// Shared constants and types for the cascaded modulo counter chain.
package mod_counter_pkg;

    localparam int DIGITS_MAX = 8;
    localparam int RADIX_MAX  = 16;

    typedef logic [$clog2(RADIX_MAX)-1:0] digit_t;

    // Values at or above the radix are not legal digit states; pin them to the top state.
    function automatic logic [31:0] clamp_digit(input logic [31:0] value, input int radix);
        logic [31:0] result;
        result = value;
        if (value >= 32'(radix)) begin
            result = 32'(radix - 1);
        end
        return result;
    endfunction

endpackage

// File: rtl/mod_counter_digit.sv
// One modulo-RADIX digit stage: reset, clamped parallel load, and up/down step with wrap.
module mod_counter_digit
    import mod_counter_pkg::*;
#(
    parameter int RADIX = 10,
    parameter int DW    = $clog2(RADIX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] load_digit,
    input  logic          step,
    input  logic          up,
    output logic [DW-1:0] value,
    output logic          tc
);

    localparam logic [DW-1:0] MAX_VAL = DW'(RADIX - 1);

    logic [DW-1:0] value_q;
    logic [DW-1:0] stepped;
    logic [DW-1:0] load_clamped;

    always_comb begin
        stepped = value_q;
        if (up) begin
            stepped = (value_q == MAX_VAL) ? '0 : value_q + DW'(1);
        end else begin
            stepped = (value_q == '0) ? MAX_VAL : value_q - DW'(1);
        end
    end

    assign load_clamped = DW'(clamp_digit(32'(load_digit), RADIX));

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else if (load) begin
            value_q <= load_clamped;
        end else if (step) begin
            value_q <= stepped;
        end
    end

    assign value = value_q;
    assign tc    = up ? (value_q == MAX_VAL) : (value_q == '0);

endmodule

// File: rtl/mod_counter_chain.sv
// Cascaded DIGITS x modulo-RADIX up/down counter with load and chain carry.
// Define MOD_COUNTER_CHAIN_SATURATE_EN to hold at full terminal instead of wrapping.
module mod_counter_chain
    import mod_counter_pkg::*;
#(
    parameter  int DIGITS = 2,
    parameter  int RADIX  = 10,
    localparam int DW     = $clog2(RADIX)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 up,
    input  logic                 load,
    input  logic [DIGITS*DW-1:0] load_val,
    output logic [DIGITS*DW-1:0] count,
    output logic [DIGITS-1:0]    tc,
    output logic                 carry_out
);

    logic [DIGITS-1:0] tc_vec;
    logic [DIGITS-1:0] step_in;
    logic              all_tc;
    logic              en_eff;

    assign all_tc = &tc_vec;

`ifdef MOD_COUNTER_CHAIN_SATURATE_EN
    // Sitting at the terminal count in the stepping direction: freeze rather than wrap.
    assign en_eff = en & ~all_tc;
`else
    assign en_eff = en;
`endif

    // Digit i steps only when every lower digit is at its terminal state.
    always_comb begin
        step_in = '0;
        step_in[0] = en_eff;
        for (int i = 1; i < DIGITS; i++) begin
            step_in[i] = step_in[i-1] & tc_vec[i-1];
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        mod_counter_digit #(
            .RADIX (RADIX),
            .DW    (DW)
        ) u_digit (
            .clk        (clk),
            .rst        (rst),
            .load       (load),
            .load_digit (load_val[g*DW +: DW]),
            .step       (step_in[g]),
            .up         (up),
            .value      (count[g*DW +: DW]),
            .tc         (tc_vec[g])
        );
    end

    assign tc        = tc_vec;
    assign carry_out = en & all_tc;

endmodule

// File: tb/tb_mod_counter_chain.sv
// Randomized self-checking bench for mod_counter_chain against an integer-valued reference model.
module tb_mod_counter_chain;

   localparam int DIGITS = 2;
   localparam int RADIX  = 10;
   localparam int DW     = $clog2(RADIX);
   localparam int TOTAL  = RADIX ** DIGITS;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 en;
   logic                 up;
   logic                 load;
   logic [DIGITS*DW-1:0] load_val;
   logic [DIGITS*DW-1:0] count;
   logic [DIGITS-1:0]    tc;
   logic                 carry_out;

   int checks = 0;
   int passed = 0;
   int model_n = 0;

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   mod_counter_chain #(
      .DIGITS (DIGITS),
      .RADIX  (RADIX)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .up        (up),
      .load      (load),
      .load_val  (load_val),
      .count     (count),
      .tc        (tc),
      .carry_out (carry_out)
   );

   // The model keeps the whole chain as one integer; digits are extracted arithmetically.
   function automatic int digitOf(input int n, input int i);
      return (n / (RADIX ** i)) % RADIX;
   endfunction

   function automatic logic [DIGITS*DW-1:0] toPacked(input int n);
      logic [DIGITS*DW-1:0] r;
      r = '0;
      for (int i = 0; i < DIGITS; i++) begin
         r[i*DW +: DW] = DW'(digitOf(n, i));
      end
      return r;
   endfunction

   function automatic logic [DIGITS-1:0] expectedTc(input int n, input logic u);
      logic [DIGITS-1:0] r;
      for (int i = 0; i < DIGITS; i++) begin
         r[i] = u ? (digitOf(n, i) == RADIX - 1) : (digitOf(n, i) == 0);
      end
      return r;
   endfunction

   function automatic int loadModel(input logic [DIGITS*DW-1:0] lv);
      int n;
      int d;
      n = 0;
      for (int i = 0; i < DIGITS; i++) begin
         d = int'(lv[i*DW +: DW]);
         if (d >= RADIX) d = RADIX - 1;
         n += d * (RADIX ** i);
      end
      return n;
   endfunction

   function automatic bit atTerminal(input int n, input logic u);
      return u ? (n == TOTAL - 1) : (n == 0);
   endfunction

   // Every comparison in the bench funnels through here.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) begin
         passed++;
      end else begin
         $display("[TB] FAIL %s: got %0h expected %0h (model count %0d)", tag, got, exp, model_n);
      end
   endtask

   // Drive one cycle of inputs, check combinational outputs, clock, update model, check count.
   task automatic applyStimulus(input logic r, input logic l, input logic e, input logic u,
                                input logic [DIGITS*DW-1:0] lv);
      bit hold;
      rst      = r;
      load     = l;
      en       = e;
      up       = u;
      load_val = lv;
      #1;
      checkOutput("tc", 32'(tc), 32'(expectedTc(model_n, u)));
      checkOutput("carry_out", 32'(carry_out), 32'(e && atTerminal(model_n, u)));
      @(posedge clk);
      if (r) begin
         model_n = 0;
      end else if (l) begin
         model_n = loadModel(lv);
      end else if (e) begin
         hold = 1'b0;
`ifdef MOD_COUNTER_CHAIN_SATURATE_EN
         hold = atTerminal(model_n, u);
`endif
         if (!hold) begin
            model_n = u ? (model_n + 1) % TOTAL : (model_n + TOTAL - 1) % TOTAL;
         end
      end
      #1;
      checkOutput("count", 32'(count), 32'(toPacked(model_n)));
   endtask

   // Directed scenarios first, then a randomized soak.
   initial begin
      rst      = 1'b1;
      en       = 1'b0;
      up       = 1'b1;
      load     = 1'b0;
      load_val = '0;
      repeat (2) @(posedge clk);
      #1;
      model_n = 0;

      $display("[TB] reset with en held high");
      repeat (2) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, '0);

      $display("[TB] count up through full wrap");
      repeat (100) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, '0);
      checkOutput("up_wrap_zero", 32'(count), 32'h0);

      $display("[TB] count down from zero");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, '0);
      repeat (15) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0);

      $display("[TB] load clamp and priority over enable");
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'hC5);
      checkOutput("load_clamp", 32'(count), 32'h95);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, '0);
      checkOutput("load_step", 32'(count), 32'h96);

      $display("[TB] reset beats load mid-count");
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h57);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h33);
      checkOutput("reset_mid", 32'(count), 32'h0);

`ifdef MOD_COUNTER_CHAIN_SATURATE_EN
      $display("[TB] saturation at full terminal");
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h99);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, '0);
      checkOutput("sat_hold", 32'(count), 32'h99);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0);
      checkOutput("sat_leave", 32'(count), 32'h98);
`endif

      $display("[TB] randomized soak");
      for (int k = 0; k < 500; k++) begin
         applyStimulus(($urandom_range(39) == 0), ($urandom_range(9) == 0),
                       ($urandom_range(3) != 0), 1'($urandom),
                       (DIGITS*DW)'($urandom));
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
